pipelined_cpu: RTL and testbench
================================

PIPELINED_CPU -- requirements
Module: pipelined_cpu

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 256, number of 16-bit instruction_mem words.
REQ-002 SHALL have parameter DMEM_DEPTH, default 256, number of 8-bit data_mem bytes.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have no other ports; state is observed hierarchically.
REQ-006 SHALL expose internal arrays under these exact names, with these shapes: instruction_mem [IMEM_DEPTH] x 16 bits, reg_file [16] x 8 bits, data_mem [DMEM_DEPTH] x 8 bits.

Function
REQ-007 SHALL use instruction format [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
REQ-008 SHALL implement opcode 0 ADD: rd <= rs1 + rs2, 8-bit, carry discarded (modulo 256).
REQ-009 SHALL implement opcode 1 SUB: rd <= rs1 - rs2, 8-bit two's complement wrap (0 - 1 = 255).
REQ-010 SHALL implement opcode 2 LOAD: rd <= data_mem[reg_file[rs1]]; rs2 ignored.
REQ-011 SHALL treat opcodes 3-15 as NOP: no register or memory write.
REQ-012 SHALL be a 5-stage pipeline IF, ID, EX, MEM, WB, one instruction issued per cycle absent stalls.
REQ-013 SHALL use an 8-bit PC, incremented by 1 per fetch, wrapping from IMEM_DEPTH-1 to 0.
REQ-014 SHALL write reg_file only in WB, on the rising edge; results become architecturally visible 5 cycles after fetch.
REQ-015 SHALL let a WB write in cycle N be seen by an ID read of the same register in cycle N (write-before-read bypass).
REQ-016 SHALL forward EX operands from EX/MEM (ALU result) and MEM/WB (ALU or load result); the youngest producer wins.
REQ-017 SHALL stall IF/ID for one cycle and insert a NOP bubble into EX when an instruction in ID reads the rd of a LOAD currently in EX (load-use).
REQ-018 SHALL forward only when the producer is a writing opcode (0-2); NOPs never forward.
REQ-019 SHALL read data_mem combinationally in MEM, using the low 8 bits of the address taken modulo DMEM_DEPTH.
REQ-020 SHALL never write data_mem or instruction_mem from the pipeline.
REQ-021 SHALL run continuously after reset; there is no halt, and NOP words execute harmlessly.

Reset
REQ-022 SHALL, while reset = 0, asynchronously clear PC to 0 and all pipeline registers to NOP (opcode 3, no write).
REQ-023 SHALL NOT modify reg_file, data_mem or instruction_mem on reset, so preloaded contents survive.
REQ-024 SHALL fetch instruction_mem[0] on the first rising edge after reset rises to 1.
REQ-025 SHALL abort all in-flight instructions without writeback when reset is asserted mid-operation.

Verification
REQ-026 Preload reg_file[2]=10, reg_file[3]=5, instruction_mem[0]=0x0123 (ADD R1,R2,R3); release reset -> reg_file[1]=15 within 6 cycles.
REQ-027 Next instruction_mem[1]=0x1413 (SUB R4,R1,R3) back-to-back -> reg_file[4]=10, proving EX/MEM forwarding.
REQ-028 instruction_mem[2]=0x2580 (LOAD R5,[R8]), reg_file[8]=2, data_mem[2]=99 -> reg_file[5]=99; all three done within 10 cycles of reset release.
REQ-029 LOAD R6,[R8] then ADD R7,R6,R3 -> exactly one stall cycle; reg_file[7]=104.
REQ-030 ADD of 200 and 100 -> 44 (wrap); SUB 0 - 1 -> 255; opcode 0xF word -> no reg_file change.
REQ-031 Assert reset mid-stream -> PC = 0, no further writeback; reg_file keeps prior values; re-execution after release gives the same results.

Source files
------------

// File: rtl/pipelined_cpu.sv
// Five-stage IF/ID/EX/MEM/WB CPU with ADD, SUB and LOAD, full forwarding and load-use stall.
// Memories and the register file are plain arrays, loaded and observed hierarchically.
module pipelined_cpu #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic clk,
    input  logic reset
);
    localparam logic [3:0]  OP_ADD   = 4'd0;
    localparam logic [3:0]  OP_SUB   = 4'd1;
    localparam logic [3:0]  OP_LOAD  = 4'd2;
    localparam logic [3:0]  OP_NOP   = 4'd3;
    localparam logic [15:0] NOP_WORD = 16'h3000;

    logic [15:0] instruction_mem [IMEM_DEPTH];
    logic [7:0]  reg_file        [16];
    logic [7:0]  data_mem        [DMEM_DEPTH];

    function automatic logic writes_rd(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOAD);
    endfunction

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    logic [7:0]  pc_q, pc_d;
    logic [15:0] if_id_instr_q, if_id_instr_d;
    logic [3:0]  id_ex_op_q, id_ex_op_d, ex_mem_op_q, mem_wb_op_q;

    logic [3:0]  id_ex_rd_q, id_ex_rs1_q, id_ex_rs2_q, ex_mem_rd_q, mem_wb_rd_q;
    logic [7:0]  id_ex_a_q, id_ex_b_q, ex_mem_res_q, mem_wb_data_q;

    logic [3:0]  id_op, id_rd, id_rs1, id_rs2;
    logic [7:0]  id_a, id_b;
    logic        wb_we, load_use;
    logic [7:0]  ex_a, ex_b, ex_res;
    logic [7:0]  mem_addr, mem_data;

    assign {id_op, id_rd, id_rs1, id_rs2} = if_id_instr_q;
    assign wb_we = writes_rd(mem_wb_op_q);

    // IF / ID: register read with same-cycle WB bypass, load-use stall
    always_comb begin
        id_a = reg_file[id_rs1];
        id_b = reg_file[id_rs2];
        if (wb_we && (mem_wb_rd_q == id_rs1)) id_a = mem_wb_data_q;
        if (wb_we && (mem_wb_rd_q == id_rs2)) id_b = mem_wb_data_q;

        // LOAD reads only rs1; ADD/SUB read both sources
        load_use = (id_ex_op_q == OP_LOAD) &&
                   ((writes_rd(id_op) && (id_ex_rd_q == id_rs1)) ||
                    (is_alu(id_op)    && (id_ex_rd_q == id_rs2)));

        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        id_ex_op_d    = OP_NOP;
        if (!load_use) begin
            pc_d          = (pc_q == 8'(IMEM_DEPTH - 1)) ? 8'd0 : pc_q + 8'd1;
            if_id_instr_d = instruction_mem[pc_q];
            id_ex_op_d    = id_op;
        end
    end

    // EX: youngest producer wins, so EX/MEM overrides MEM/WB
    always_comb begin
        ex_a = id_ex_a_q;
        ex_b = id_ex_b_q;
        if (wb_we && (mem_wb_rd_q == id_ex_rs1_q)) ex_a = mem_wb_data_q;
        if (wb_we && (mem_wb_rd_q == id_ex_rs2_q)) ex_b = mem_wb_data_q;
        if (is_alu(ex_mem_op_q) && (ex_mem_rd_q == id_ex_rs1_q)) ex_a = ex_mem_res_q;
        if (is_alu(ex_mem_op_q) && (ex_mem_rd_q == id_ex_rs2_q)) ex_b = ex_mem_res_q;

        case (id_ex_op_q)
            OP_ADD:  ex_res = ex_a + ex_b;
            OP_SUB:  ex_res = ex_a - ex_b;
            default: ex_res = ex_a;
        endcase
    end

    // MEM: combinational data read; LOAD carries its address in the result field
    always_comb begin
        mem_addr = 8'(32'(ex_mem_res_q) % DMEM_DEPTH);
        mem_data = (ex_mem_op_q == OP_LOAD) ? data_mem[mem_addr] : ex_mem_res_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= 8'd0;
            if_id_instr_q <= NOP_WORD;
            id_ex_op_q    <= OP_NOP;
            ex_mem_op_q   <= OP_NOP;
            mem_wb_op_q   <= OP_NOP;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            id_ex_op_q    <= id_ex_op_d;
            ex_mem_op_q   <= id_ex_op_q;
            mem_wb_op_q   <= ex_mem_op_q;
        end
    end

    always_ff @(posedge clk) begin
        id_ex_rd_q    <= id_rd;
        id_ex_rs1_q   <= id_rs1;
        id_ex_rs2_q   <= id_rs2;
        id_ex_a_q     <= id_a;
        id_ex_b_q     <= id_b;
        ex_mem_rd_q   <= id_ex_rd_q;
        ex_mem_res_q  <= ex_res;
        mem_wb_rd_q   <= ex_mem_rd_q;
        mem_wb_data_q <= mem_data;
    end

    // WB: reg_file is deliberately outside reset so preloaded values survive
    always_ff @(posedge clk) begin
        if (wb_we) reg_file[mem_wb_rd_q] <= mem_wb_data_q;
    end

    // Pipeline never writes the memories; the self-hold keeps them as plain state
    always_ff @(posedge clk) begin
        instruction_mem <= instruction_mem;
        data_mem        <= data_mem;
    end
endmodule

// File: tb/tb_pipelined_cpu.sv
// Bench for pipelined_cpu: directed timing/forwarding/reset scenarios plus random programs
// checked against an instruction-at-a-time reference model.
module tb_pipelined_cpu;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipelined_cpu #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
        .clk   (clk),
        .reset (reset)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_regs [16];
    logic [7:0] m_dmem [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_directed();
        for (int i = 0; i < 256; i++) begin
            dut.instruction_mem[i] = 16'h3000;
            dut.data_mem[i]        = 8'd0;
        end
        for (int i = 0; i < 16; i++) dut.reg_file[i] = 8'd0;
        dut.reg_file[2]  = 8'd10;
        dut.reg_file[3]  = 8'd5;
        dut.reg_file[8]  = 8'd2;
        dut.reg_file[9]  = 8'd200;
        dut.reg_file[10] = 8'd100;
        dut.reg_file[12] = 8'd0;
        dut.reg_file[13] = 8'd1;
        dut.data_mem[2]  = 8'd99;
        dut.instruction_mem[0] = 16'h0123; // ADD  R1,R2,R3
        dut.instruction_mem[1] = 16'h1413; // SUB  R4,R1,R3
        dut.instruction_mem[2] = 16'h2580; // LOAD R5,[R8]
        dut.instruction_mem[3] = 16'h2680; // LOAD R6,[R8]
        dut.instruction_mem[4] = 16'h0763; // ADD  R7,R6,R3 (load-use)
        dut.instruction_mem[5] = 16'h0B9A; // ADD  R11,R9,R10
        dut.instruction_mem[6] = 16'h1ECD; // SUB  R14,R12,R13
        dut.instruction_mem[7] = 16'hF923; // opcode 15: no write
    endtask

    // Releases reset at the current negedge and checks results edge by edge.
    task automatic run_directed();
        logic [7:0] r1_pre, r7_pre;
        r1_pre = dut.reg_file[1];
        r7_pre = dut.reg_file[7];
        reset = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step(1);
            case (e)
                1:  chk("first_fetch", dut.if_id_instr_q, 16'h0123);
                4:  chk("r1_before_wb", dut.reg_file[1], r1_pre);
                5:  chk("add_r1", dut.reg_file[1], 15);
                6:  chk("sub_fwd_r4", dut.reg_file[4], 10);
                7:  chk("load_r5", dut.reg_file[5], 99);
                9:  chk("r7_stalled", dut.reg_file[7], r7_pre);
                10: chk("loaduse_r7", dut.reg_file[7], 104);
                14: begin
                    chk("load_r6", dut.reg_file[6], 99);
                    chk("add_wrap_r11", dut.reg_file[11], 44);
                    chk("sub_wrap_r14", dut.reg_file[14], 255);
                    chk("nop15_r9", dut.reg_file[9], 200);
                    chk("final_r1", dut.reg_file[1], 15);
                end
                default: ;
            endcase
        end
    endtask

    task automatic run_random(input int round);
        logic [15:0] prog [40];
        logic [3:0]  op, rd, rs1, rs2;
        int          sel;
        for (int i = 0; i < 256; i++) begin
            dut.instruction_mem[i] = 16'h3000;
            m_dmem[i]              = 8'($urandom);
            dut.data_mem[i]        = m_dmem[i];
        end
        for (int i = 0; i < 16; i++) begin
            m_regs[i]       = 8'($urandom);
            dut.reg_file[i] = m_regs[i];
        end
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 3));
            op  = (sel < 3) ? 4'(sel) : 4'($urandom_range(3, 15));
            prog[i] = {op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15))};
            dut.instruction_mem[i] = prog[i];
        end
        for (int i = 0; i < 40; i++) begin
            {op, rd, rs1, rs2} = prog[i];
            if (op == 4'd0)      m_regs[rd] = m_regs[rs1] + m_regs[rs2];
            else if (op == 4'd1) m_regs[rd] = m_regs[rs1] - m_regs[rs2];
            else if (op == 4'd2) m_regs[rd] = m_dmem[m_regs[rs1]];
        end
        reset = 1'b1;
        step(100);
        for (int i = 0; i < 16; i++)
            chk($sformatf("rnd%0d_r%0d", round, i), dut.reg_file[i], m_regs[i]);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        load_directed();
        step(2);
        chk("rst_pc", dut.pc_q, 0);
        chk("rst_ifid", dut.if_id_instr_q, 16'h3000);
        chk("rst_wb_op", dut.mem_wb_op_q, 3);
        chk("rst_keeps_r2", dut.reg_file[2], 10);

        run_directed();

        // mid-stream abort: R1/R4 retired, R5 still in flight
        reset = 1'b0;
        #1;
        chk("abort0_pc", dut.pc_q, 0);
        load_directed();
        @(negedge clk);
        reset = 1'b1;
        step(6);
        chk("pre_abort_r4", dut.reg_file[4], 10);
        reset = 1'b0;
        #1;
        chk("abort_pc", dut.pc_q, 0);
        chk("abort_wb_op", dut.mem_wb_op_q, 3);
        step(3);
        chk("abort_r5", dut.reg_file[5], 0);
        chk("abort_r6", dut.reg_file[6], 0);
        chk("abort_r7", dut.reg_file[7], 0);
        chk("abort_keep_r1", dut.reg_file[1], 15);
        run_directed();
        reset = 1'b0;
        step(1);

        for (int r = 0; r < 4; r++) run_random(r);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
